// File: rtl/hc_wr_dispatch.sv
// Write-dispatch stage: pops FIFO lines into host write requests at consecutive line addresses,
// throttled by host almost-full and an in-flight cap. Define HC_WR_FENCE_EN for a trailing write fence.
module hc_wr_dispatch #(
    parameter int HC_DATA_WIDTH      = 512,
    parameter int HC_ADDR_WIDTH      = 42,
    parameter int HC_LEN_WIDTH       = 32,
    parameter int HC_MAX_OUTSTANDING = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [HC_ADDR_WIDTH-1:0] base_addr,
    input  logic [HC_LEN_WIDTH-1:0]  num_lines,
    input  logic [HC_DATA_WIDTH-1:0] fifo_deq_data,
    input  logic                     fifo_not_empty,
    output logic                     fifo_deq_en,
    output logic                     wr_req_valid,
    output logic [HC_ADDR_WIDTH-1:0] wr_req_addr,
    output logic [HC_DATA_WIDTH-1:0] wr_req_data,
    output logic                     wr_req_fence,
    input  logic                     wr_req_almfull,
    input  logic                     wr_rsp_valid,
    output logic                     busy,
    output logic                     done,
    output logic [HC_LEN_WIDTH-1:0]  lines_acked
);

    localparam int OUT_W = $clog2(HC_MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0]        OUT_ONE = OUT_W'(1);
    localparam logic [OUT_W-1:0]        OUT_MAX = OUT_W'(HC_MAX_OUTSTANDING);
    localparam logic [HC_LEN_WIDTH-1:0] LEN_ONE = HC_LEN_WIDTH'(1);

`ifdef HC_WR_FENCE_EN
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FENCE, FENCE_WAIT, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif

    state_t                    state;
    logic [HC_ADDR_WIDTH-1:0]  base_r;
    logic [HC_LEN_WIDTH-1:0]   num_r;
    logic [HC_LEN_WIDTH-1:0]   issued;
    logic [OUT_W-1:0]          outstanding;
    logic                      pop;
    logic                      rsp_ok;

    assign pop = (state == RUN) && fifo_not_empty && !wr_req_almfull
                 && (issued < num_r) && (outstanding < OUT_MAX);
    // Responses with nothing in flight are stray and must not disturb the counters.
    assign rsp_ok      = wr_rsp_valid && (outstanding != '0);
    assign fifo_deq_en = pop;
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);

`ifndef HC_WR_FENCE_EN
    assign wr_req_fence = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            base_r       <= '0;
            num_r        <= '0;
            issued       <= '0;
            outstanding  <= '0;
            lines_acked  <= '0;
            wr_req_valid <= 1'b0;
            wr_req_addr  <= '0;
            wr_req_data  <= '0;
`ifdef HC_WR_FENCE_EN
            wr_req_fence <= 1'b0;
`endif
        end else begin
            wr_req_valid <= pop;
`ifdef HC_WR_FENCE_EN
            wr_req_fence <= 1'b0;
`endif
            if (pop) begin
                wr_req_data <= fifo_deq_data;
                wr_req_addr <= base_r + HC_ADDR_WIDTH'(issued);
                issued      <= issued + LEN_ONE;
            end

            if (pop && !rsp_ok)
                outstanding <= outstanding + OUT_ONE;
            else if (!pop && rsp_ok)
                outstanding <= outstanding - OUT_ONE;

            if (rsp_ok && (lines_acked < num_r))
                lines_acked <= lines_acked + LEN_ONE;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base_r      <= base_addr;
                        num_r       <= num_lines;
                        issued      <= '0;
                        outstanding <= '0;
                        lines_acked <= '0;
                        // An empty job skips straight to the completion check.
                        state       <= (num_lines == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (pop && ((issued + LEN_ONE) == num_r))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if ((lines_acked == num_r) && (outstanding == '0)) begin
`ifdef HC_WR_FENCE_EN
                        state <= FENCE;
`else
                        state <= DONE;
`endif
                    end
                end
`ifdef HC_WR_FENCE_EN
                FENCE: begin
                    wr_req_valid <= 1'b1;
                    wr_req_fence <= 1'b1;
                    state        <= FENCE_WAIT;
                end
                FENCE_WAIT: begin
                    if (wr_rsp_valid)
                        state <= DONE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
